// File: rtl/instr_sequencer.sv
// Program store and sequencer: steps a host-loaded program and broadcasts
// core opcodes, handling jump / counted loop / end internally.
module instr_sequencer #(
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [15:0]           prog_data,
    input  logic                  start,
    input  logic                  hold,
    output logic [15:0]           opcode,
    output logic                  execute,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] pc
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state;
    logic [15:0]           mem [PROG_DEPTH];
    logic [15:0]           instr;
    logic [7:0]            loop_cnt;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] tgt;
    logic                  is_ctrl;

    assign instr   = mem[pc];
    assign pc_next = pc + 1'b1;
    assign tgt     = instr[ADDR_WIDTH-1:0];
    assign is_ctrl = (instr[15:14] == 2'b10);

    // Program words survive reset; only an idle sequencer accepts writes.
    always_ff @(posedge clk) begin
        if (prog_we && state == IDLE)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            opcode   <= '0;
            execute  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            loop_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    execute <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        pc    <= '0;
                    end
                end
                RUN: begin
                    if (hold) begin
                        execute <= 1'b0;
                    end else if (!is_ctrl) begin
                        opcode  <= instr;
                        execute <= 1'b1;
                        pc      <= pc_next;
                    end else begin
                        // Control words are a bubble; opcode keeps its value.
                        execute <= 1'b0;
                        unique case (instr[13:12])
                            2'b00: pc <= tgt;
                            2'b01: begin
                                loop_cnt <= instr[7:0];
                                pc       <= pc_next;
                            end
                            2'b10: begin
                                if (loop_cnt != 8'd0) begin
                                    loop_cnt <= loop_cnt - 8'd1;
                                    pc       <= tgt;
                                end else begin
                                    pc <= pc_next;
                                end
                            end
                            2'b11: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pc    <= '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, issue, loops, hold,
// busy-time writes/start, mid-run reset and wrap with a model.
module tb_instr_sequencer;

    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          start;
    logic          hold;
    logic [15:0]   opcode;
    logic          execute;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    int n_chk = 0;
    int n_pass = 0;

    instr_sequencer #(.PROG_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .start(start),
        .hold(hold),
        .opcode(opcode),
        .execute(execute),
        .busy(busy),
        .done(done),
        .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_chk++;
        if ({opcode, execute, busy, done, pc} !== {16'h0000, 1'b0, 1'b0, 1'b0, 5'd0})
            $display("FAIL reset_outputs: got op=%h ex=%b busy=%b done=%b pc=%0d want 0000/0/0/0/0",
                     opcode, execute, busy, done, pc);
        else n_pass++;
        n_chk++;
        if (dut.loop_cnt !== 8'd0)
            $display("FAIL reset_loop_cnt: got %0d want 0", dut.loop_cnt);
        else n_pass++;
    endtask

    task automatic test_basic();
        load(0, 16'h0005);
        load(1, 16'h4400);
        load(2, 16'hB000);
        do_start();
        n_chk++;
        if ({busy, execute} !== 2'b10)
            $display("FAIL basic_fetch: got busy=%b ex=%b want 1/0", busy, execute);
        else n_pass++;
        tick();
        n_chk++;
        if ({execute, opcode, pc} !== {1'b1, 16'h0005, 5'd1})
            $display("FAIL basic_op0: got ex=%b op=%h pc=%0d want 1/0005/1", execute, opcode, pc);
        else n_pass++;
        tick();
        n_chk++;
        if ({execute, opcode, pc} !== {1'b1, 16'h4400, 5'd2})
            $display("FAIL basic_op1: got ex=%b op=%h pc=%0d want 1/4400/2", execute, opcode, pc);
        else n_pass++;
        tick();
        n_chk++;
        if ({execute, done, busy, pc, opcode} !== {1'b0, 1'b1, 1'b0, 5'd0, 16'h4400})
            $display("FAIL basic_end: got ex=%b done=%b busy=%b pc=%0d op=%h want 0/1/0/0/4400",
                     execute, done, busy, pc, opcode);
        else n_pass++;
        tick();
        n_chk++;
        if ({execute, done, busy} !== 3'b000)
            $display("FAIL basic_after: got ex=%b done=%b busy=%b want 0/0/0", execute, done, busy);
        else n_pass++;
    endtask

    task automatic test_loop();
        int issues;
        int done_at;
        logic exp_ex;
        issues  = 0;
        done_at = -1;
        load(0, 16'h9003);
        load(1, 16'h4400);
        load(2, 16'hA001);
        load(3, 16'hB000);
        do_start();
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_ex = (i == 2 || i == 4 || i == 6 || i == 8);
            if (i <= 10) begin
                n_chk++;
                if (execute !== exp_ex)
                    $display("FAIL loop_exec_t%0d: got %b want %b", i, execute, exp_ex);
                else n_pass++;
            end
            if (execute && opcode == 16'h4400) issues++;
            if (done && done_at < 0) done_at = i;
        end
        n_chk++;
        if (issues !== 4)
            $display("FAIL loop_issue_count: got %0d want 4", issues);
        else n_pass++;
        n_chk++;
        if (done_at !== 10)
            $display("FAIL loop_done_cycle: got %0d want 10", done_at);
        else n_pass++;
        n_chk++;
        if (dut.loop_cnt !== 8'd0)
            $display("FAIL loop_cnt_end: got %0d want 0", dut.loop_cnt);
        else n_pass++;
    endtask

    task automatic test_hold();
        load(0, 16'h0001);
        load(1, 16'h0002);
        load(2, 16'h0003);
        load(3, 16'h0004);
        load(4, 16'hB000);
        do_start();
        tick();
        n_chk++;
        if ({execute, opcode, pc} !== {1'b1, 16'h0001, 5'd1})
            $display("FAIL hold_first: got ex=%b op=%h pc=%0d want 1/0001/1", execute, opcode, pc);
        else n_pass++;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({execute, opcode, pc} !== {1'b0, 16'h0001, 5'd1})
                $display("FAIL hold_stall%0d: got ex=%b op=%h pc=%0d want 0/0001/1",
                         i, execute, opcode, pc);
            else n_pass++;
        end
        hold = 1'b0;
        tick();
        n_chk++;
        if ({execute, opcode, pc} !== {1'b1, 16'h0002, 5'd2})
            $display("FAIL hold_resume: got ex=%b op=%h pc=%0d want 1/0002/2", execute, opcode, pc);
        else n_pass++;
        tick();
        n_chk++;
        if ({execute, opcode} !== {1'b1, 16'h0003})
            $display("FAIL hold_next: got ex=%b op=%h want 1/0003", execute, opcode);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_busy_writes();
        load(0, 16'h0011);
        load(1, 16'h0022);
        load(2, 16'h0033);
        load(3, 16'hB000);
        do_start();
        tick();
        prog_we   = 1'b1;
        prog_addr = 5'd1;
        prog_data = 16'h1234;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        n_chk++;
        if ({execute, opcode, pc} !== {1'b1, 16'h0022, 5'd2})
            $display("FAIL busy_start_ignored: got ex=%b op=%h pc=%0d want 1/0022/2",
                     execute, opcode, pc);
        else n_pass++;
        tick();
        tick();
        n_chk++;
        if ({done, busy} !== 2'b10)
            $display("FAIL busy_run_end: got done=%b busy=%b want 1/0", done, busy);
        else n_pass++;
        tick();
        do_start();
        tick();
        tick();
        n_chk++;
        if ({execute, opcode} !== {1'b1, 16'h0022})
            $display("FAIL busy_write_dropped: got ex=%b op=%h want 1/0022", execute, opcode);
        else n_pass++;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_midrun();
        load(0, 16'h9010);
        load(1, 16'h4400);
        load(2, 16'hA001);
        load(3, 16'hB000);
        do_start();
        for (int i = 0; i < 4; i++) tick();
        n_chk++;
        if ({execute, busy} !== 2'b11)
            $display("FAIL midrun_active: got ex=%b busy=%b want 1/1", execute, busy);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if ({execute, busy, pc, opcode} !== {1'b0, 1'b0, 5'd0, 16'h0000})
            $display("FAIL midrun_reset: got ex=%b busy=%b pc=%0d op=%h want 0/0/0/0000",
                     execute, busy, pc, opcode);
        else n_pass++;
        do_start();
        tick();
        n_chk++;
        if ({execute, pc} !== {1'b0, 5'd1})
            $display("FAIL midrun_restart_setcnt: got ex=%b pc=%0d want 0/1", execute, pc);
        else n_pass++;
        tick();
        n_chk++;
        if ({execute, opcode, pc} !== {1'b1, 16'h4400, 5'd2})
            $display("FAIL midrun_restart_issue: got ex=%b op=%h pc=%0d want 1/4400/2",
                     execute, opcode, pc);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] mmem [DEPTH];
        logic [AW-1:0] mpc;
        logic [15:0] mop;
        logic mex;
        int errs;
        for (int i = 0; i < DEPTH - 1; i++) mmem[i] = 16'h1000 + 16'(i);
        mmem[DEPTH-1] = 16'h8005;
        for (int i = 0; i < DEPTH; i++) load(AW'(i), mmem[i]);
        do_start();
        mpc  = '0;
        mop  = '0;
        mex  = 1'b0;
        errs = 0;
        for (int t = 0; t < 120; t++) begin
            tick();
            if (mpc == AW'(DEPTH - 1)) begin
                mex = 1'b0;
                mpc = 5'd5;
            end else begin
                mop = mmem[mpc];
                mex = 1'b1;
                mpc = mpc + 1'b1;
            end
            n_chk++;
            if ({execute, opcode, pc, busy} !== {mex, mop, mpc, 1'b1}) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL wrap_t%0d: got ex=%b op=%h pc=%0d busy=%b want %b/%h/%0d/1",
                             t, execute, opcode, pc, busy, mex, mop, mpc);
            end else n_pass++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        hold      = 1'b0;
        test_reset();
        test_basic();
        test_loop();
        test_hold();
        test_busy_writes();
        test_reset_midrun();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
